csr_access_unit: RTL and testbench

- Initiator side of the CSR read/write port. Executes RISC-V Zicsr instructions (CSRRW/CSRRS/CSRRC and the immediate forms CSRRWI/CSRRSI/CSRRCI) as a read-modify-write sequence against the CSR file.
- Sits in the execute stage. Accepts one request at a time from issue over a valid/ready handshake.
- Drives the CSR file's read address, write address, write data and write enable.
- Returns the old CSR value, the destination register and an illegal-instruction flag to writeback.

---
 rtl/csr_access_unit.sv | 235 +++++++++++++++++++++++
 tb/tb_csr_access_unit.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_access_unit.sv
// ---------------------------------------------------------------------------
// csr_access_unit
//
// Purpose:
//   Initiator side of the CSR read/write port. Executes the Zicsr
//   instructions (CSRRW/CSRRS/CSRRC and the CSRRWI/CSRRSI/CSRRCI immediate
//   forms) as a read-modify-write sequence against the CSR file.
//   IDLE -> READ -> WRITE -> RESP, so one instruction takes at least
//   4 cycles.
//
// Handshakes:
//   Both req_* and resp_* use valid/ready. A transfer happens on a rising
//   clk edge where valid and ready are both 1. The sender holds its payload
//   stable while valid is 1 and ready is 0. In addition, flush_i in IDLE
//   suppresses acceptance even though req_ready_o reads 1.
//
// Optional feature:
//   CSR_ACCESS_PERF_EN - when defined, perf_ops_o and perf_illegal_o are
//   32-bit wrapping counters of response handshakes and of illegal
//   responses. When undefined, both ports are tied to 0.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   req_valid_i/ready_o   request handshake from issue
//   req_funct3_i          Zicsr funct3
//   req_addr_i            CSR address
//   req_src_i             rs1 value, or zero-extended zimm
//   req_rs1_idx_i         rs1 index / zimm; zero suppresses RS/RC writes
//   req_rd_i              destination register
//   flush_i               pipeline flush; aborts an access still in READ
//   csr_raddr_o           CSR file read address (data returns combinationally)
//   csr_rdata_i           CSR file read data
//   csr_waddr_o/wdata_o   CSR file write address / data
//   csr_we_o              CSR file write enable, single-cycle pulse
//   resp_valid_o/ready_i  response handshake to writeback
//   resp_rdata_o          old CSR value (0 when illegal)
//   resp_rd_o             destination register
//   resp_illegal_o        illegal-instruction flag
//   perf_ops_o            completed-access counter
//   perf_illegal_o        illegal-access counter
// ---------------------------------------------------------------------------
module csr_access_unit #(
    parameter int         XLEN        = 64,
    parameter logic [1:0] RO_TOP_BITS = 2'b11
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [2:0]      req_funct3_i,
    input  logic [11:0]     req_addr_i,
    input  logic [XLEN-1:0] req_src_i,
    input  logic [4:0]      req_rs1_idx_i,
    input  logic [4:0]      req_rd_i,
    input  logic            flush_i,
    output logic [11:0]     csr_raddr_o,
    input  logic [XLEN-1:0] csr_rdata_i,
    output logic [11:0]     csr_waddr_o,
    output logic [XLEN-1:0] csr_wdata_o,
    output logic            csr_we_o,
    output logic            resp_valid_o,
    input  logic            resp_ready_i,
    output logic [XLEN-1:0] resp_rdata_o,
    output logic [4:0]      resp_rd_o,
    output logic            resp_illegal_o,
    output logic [31:0]     perf_ops_o,
    output logic [31:0]     perf_illegal_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state_q;

    // Latched request fields
    logic [1:0]      op_q;      // funct3[1:0]: 01 RW, 10 RS, 11 RC, 00 illegal
    logic [11:0]     addr_q;
    logic [XLEN-1:0] src_q;
    logic [4:0]      rs1_idx_q;
    logic [4:0]      rd_q;

    // Results of the READ cycle
    logic [XLEN-1:0] old_q;
    logic            illegal_q;

    // Registered outputs
    logic            req_ready_q;
    logic [11:0]     raddr_q;
    logic [11:0]     waddr_q;
    logic [XLEN-1:0] wdata_q;
    logic            we_q;
    logic            resp_valid_q;
    logic [XLEN-1:0] resp_rdata_q;
    logic [4:0]      resp_rd_q;
    logic            resp_illegal_q;

    // funct3[2] only selects register vs. immediate source; the source value
    // already arrives resolved in req_src_i, so the bit carries no information.
    logic unused_funct3_bit;
    assign unused_funct3_bit = req_funct3_i[2];

    // Write control and new value, evaluated during READ from latched fields.
    // RW always writes; RS/RC write only when rs1/zimm is non-zero.
    logic            wr_en;
    logic            illegal;
    logic [XLEN-1:0] new_val;

    always_comb begin
        wr_en   = (op_q == 2'b01) || (rs1_idx_q != 5'd0);
        illegal = (op_q == 2'b00) || (wr_en && (addr_q[11:10] == RO_TOP_BITS));
        case (op_q)
            2'b01:   new_val = src_q;
            2'b10:   new_val = csr_rdata_i | src_q;
            2'b11:   new_val = csr_rdata_i & ~src_q;
            default: new_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            op_q           <= '0;
            addr_q         <= '0;
            src_q          <= '0;
            rs1_idx_q      <= '0;
            rd_q           <= '0;
            old_q          <= '0;
            illegal_q      <= 1'b0;
            req_ready_q    <= 1'b1;
            raddr_q        <= '0;
            waddr_q        <= '0;
            wdata_q        <= '0;
            we_q           <= 1'b0;
            resp_valid_q   <= 1'b0;
            resp_rdata_q   <= '0;
            resp_rd_q      <= '0;
            resp_illegal_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // A flush in IDLE blocks acceptance for that cycle.
                    if (req_valid_i && !flush_i) begin
                        op_q        <= req_funct3_i[1:0];
                        addr_q      <= req_addr_i;
                        src_q       <= req_src_i;
                        rs1_idx_q   <= req_rs1_idx_i;
                        rd_q        <= req_rd_i;
                        raddr_q     <= req_addr_i;
                        req_ready_q <= 1'b0;
                        state_q     <= READ;
                    end
                end
                READ: begin
                    raddr_q <= '0;
                    if (flush_i) begin
                        // Abort before anything is committed.
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        old_q     <= csr_rdata_i;
                        illegal_q <= illegal;
                        if (wr_en && !illegal) begin
                            we_q    <= 1'b1;
                            waddr_q <= addr_q;
                            wdata_q <= new_val;
                        end
                        state_q <= WRITE;
                    end
                end
                WRITE: begin
                    // Committed from here on; flush_i is ignored.
                    we_q           <= 1'b0;
                    waddr_q        <= '0;
                    wdata_q        <= '0;
                    resp_valid_q   <= 1'b1;
                    resp_rdata_q   <= illegal_q ? '0 : old_q;
                    resp_rd_q      <= rd_q;
                    resp_illegal_q <= illegal_q;
                    state_q        <= RESP;
                end
                RESP: begin
                    if (resp_ready_i) begin
                        resp_valid_q   <= 1'b0;
                        resp_rdata_q   <= '0;
                        resp_rd_q      <= '0;
                        resp_illegal_q <= 1'b0;
                        req_ready_q    <= 1'b1;
                        state_q        <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready_o    = req_ready_q;
    assign csr_raddr_o    = raddr_q;
    assign csr_waddr_o    = waddr_q;
    assign csr_wdata_o    = wdata_q;
    assign csr_we_o       = we_q;
    assign resp_valid_o   = resp_valid_q;
    assign resp_rdata_o   = resp_rdata_q;
    assign resp_rd_o      = resp_rd_q;
    assign resp_illegal_o = resp_illegal_q;

`ifdef CSR_ACCESS_PERF_EN
    logic [31:0] perf_ops_q;
    logic [31:0] perf_illegal_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_ops_q     <= '0;
            perf_illegal_q <= '0;
        end else if (resp_valid_q && resp_ready_i) begin
            perf_ops_q <= perf_ops_q + 32'd1;
            if (resp_illegal_q) begin
                perf_illegal_q <= perf_illegal_q + 32'd1;
            end
        end
    end

    assign perf_ops_o     = perf_ops_q;
    assign perf_illegal_o = perf_illegal_q;
`else
    assign perf_ops_o     = '0;
    assign perf_illegal_o = '0;
`endif

endmodule

// File: tb/tb_csr_access_unit.sv
// ---------------------------------------------------------------------------
// tb_csr_access_unit
//
// Purpose:
//   Self-checking bench for csr_access_unit. Contains a small CSR file model
//   (array plus a free-running cycle counter at 0xC00), a table of directed
//   vectors with hand-computed results, and hand-written sequences for
//   reset, back-pressure, flush and counter reads.
//   Inputs are driven on the falling edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_csr_access_unit;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [2:0]      req_funct3 = '0;
    logic [11:0]     req_addr = '0;
    logic [XLEN-1:0] req_src = '0;
    logic [4:0]      req_rs1_idx = '0;
    logic [4:0]      req_rd = '0;
    logic            flush = 1'b0;
    logic [11:0]     csr_raddr;
    logic [XLEN-1:0] csr_rdata;
    logic [11:0]     csr_waddr;
    logic [XLEN-1:0] csr_wdata;
    logic            csr_we;
    logic            resp_valid;
    logic            resp_ready = 1'b0;
    logic [XLEN-1:0] resp_rdata;
    logic [4:0]      resp_rd;
    logic            resp_illegal;
    logic [31:0]     perf_ops;
    logic [31:0]     perf_illegal;

    always #5 clk = ~clk;

    csr_access_unit #(.XLEN(XLEN), .RO_TOP_BITS(2'b11)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_funct3_i   (req_funct3),
        .req_addr_i     (req_addr),
        .req_src_i      (req_src),
        .req_rs1_idx_i  (req_rs1_idx),
        .req_rd_i       (req_rd),
        .flush_i        (flush),
        .csr_raddr_o    (csr_raddr),
        .csr_rdata_i    (csr_rdata),
        .csr_waddr_o    (csr_waddr),
        .csr_wdata_o    (csr_wdata),
        .csr_we_o       (csr_we),
        .resp_valid_o   (resp_valid),
        .resp_ready_i   (resp_ready),
        .resp_rdata_o   (resp_rdata),
        .resp_rd_o      (resp_rd),
        .resp_illegal_o (resp_illegal),
        .perf_ops_o     (perf_ops),
        .perf_illegal_o (perf_illegal)
    );

    // ---------------- CSR file model ----------------
    logic [XLEN-1:0] csr_mem [0:4095];
    logic [XLEN-1:0] cycle_cnt = '0;
    logic            pre_we = 1'b0;
    logic [11:0]     pre_addr = '0;
    logic [XLEN-1:0] pre_data = '0;

    always @(posedge clk) begin
        cycle_cnt <= cycle_cnt + 64'd1;
        if (pre_we) csr_mem[pre_addr] <= pre_data;
        else if (csr_we) csr_mem[csr_waddr] <= csr_wdata;
    end

    assign csr_rdata = (csr_raddr == 12'hC00) ? cycle_cnt : csr_mem[csr_raddr];

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int exp_ops  = 0;
    int exp_ill  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Observations from one access, filled by collect()
    int              obs_we_cnt;
    int              obs_we_cyc;
    logic [11:0]     obs_waddr;
    logic [XLEN-1:0] obs_wdata;
    int              obs_resp_cyc;
    logic [XLEN-1:0] obs_rdata;
    logic [4:0]      obs_rd;
    logic            obs_ill;
    logic [XLEN-1:0] obs_cnt_read;

    typedef struct {
        string           name;
        logic [2:0]      funct3;
        logic [11:0]     addr;
        logic [XLEN-1:0] src;
        logic [4:0]      rs1;
        logic [4:0]      rd;
        bit              preload;
        logic [XLEN-1:0] init;
        bit              exp_we;
        logic [XLEN-1:0] exp_wdata;
        logic [XLEN-1:0] exp_rdata;
        bit              exp_ill;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(input string name, input logic [2:0] f3, input logic [11:0] a,
                                input logic [63:0] s, input logic [4:0] r1, input logic [4:0] rd,
                                input bit pl, input logic [63:0] init, input bit we,
                                input logic [63:0] wd, input logic [63:0] rdat, input bit ill);
        vec_t v;
        v.name = name; v.funct3 = f3; v.addr = a; v.src = s; v.rs1 = r1; v.rd = rd;
        v.preload = pl; v.init = init; v.exp_we = we; v.exp_wdata = wd;
        v.exp_rdata = rdat; v.exp_ill = ill;
        return v;
    endfunction

    // ---------------- driver tasks (all start and end at a negedge) ----------------
    task automatic preload(input logic [11:0] a, input logic [63:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk);
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic drive_req(input logic [2:0] f3, input logic [11:0] a, input logic [63:0] s,
                             input logic [4:0] r1, input logic [4:0] rd);
        req_valid = 1'b1; req_funct3 = f3; req_addr = a; req_src = s;
        req_rs1_idx = r1; req_rd = rd;
    endtask

    // Issue a request from IDLE; returns at the negedge of the READ cycle.
    task automatic issue(input logic [2:0] f3, input logic [11:0] a, input logic [63:0] s,
                         input logic [4:0] r1, input logic [4:0] rd);
        drive_req(f3, a, s, r1, rd);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Follows one access from its READ cycle (cycle 1 after the handshake)
    // through the response handshake. flush_cyc asserts flush_i in that cycle.
    task automatic collect(input int flush_cyc);
        int cyc;
        cyc = 1;
        obs_we_cnt = 0; obs_we_cyc = 0; obs_waddr = '0; obs_wdata = '0;
        obs_resp_cyc = 0; obs_rdata = '0; obs_rd = '0; obs_ill = 1'b0;
        obs_cnt_read = cycle_cnt;
        while (cyc <= 20 && obs_resp_cyc == 0) begin
            flush = (cyc == flush_cyc);
            if (csr_we) begin
                obs_we_cnt++; obs_we_cyc = cyc; obs_waddr = csr_waddr; obs_wdata = csr_wdata;
            end
            if (resp_valid) begin
                obs_resp_cyc = cyc; obs_rdata = resp_rdata; obs_rd = resp_rd; obs_ill = resp_illegal;
                resp_ready = 1'b1;
                exp_ops++;
                if (resp_illegal) exp_ill++;
                @(posedge clk);
                @(negedge clk);
                resp_ready = 1'b0;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        flush = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int flush_cyc);
        if (v.preload) preload(v.addr, v.init);
        issue(v.funct3, v.addr, v.src, v.rs1, v.rd);
        collect(flush_cyc);
        check({v.name, " we_count"}, 64'(obs_we_cnt), 64'(v.exp_we));
        if (v.exp_we) begin
            check({v.name, " we_cycle"}, 64'(obs_we_cyc), 64'd2);
            check({v.name, " waddr"}, 64'(obs_waddr), 64'(v.addr));
            check({v.name, " wdata"}, obs_wdata, v.exp_wdata);
            check({v.name, " csr_after"}, csr_mem[v.addr], v.exp_wdata);
        end
        check({v.name, " resp_cycle"}, 64'(obs_resp_cyc), 64'd3);
        check({v.name, " resp_rdata"}, obs_rdata, v.exp_rdata);
        check({v.name, " resp_rd"}, 64'(obs_rd), 64'(v.rd));
        check({v.name, " resp_illegal"}, 64'(obs_ill), 64'(v.exp_ill));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //           name        f3     addr    src            rs1    rd     pl  init           we  wdata          rdata          ill
        vecs[0]  = mk("rw",      3'b001, 12'h005, 64'hDEAD_BEEF, 5'd1,  5'd5,  1, 64'h1234,      1, 64'hDEAD_BEEF, 64'h1234,      0);
        vecs[1]  = mk("rs",      3'b010, 12'h003, 64'hF0,        5'd2,  5'd6,  1, 64'h0F,        1, 64'hFF,        64'h0F,        0);
        vecs[2]  = mk("rc",      3'b011, 12'h003, 64'h0F,        5'd3,  5'd7,  0, 64'h0,         1, 64'hF0,        64'hFF,        0);
        vecs[3]  = mk("f3_100",  3'b100, 12'h005, 64'h1,         5'd1,  5'd8,  1, 64'h55,        0, 64'h0,         64'h0,         1);
        vecs[4]  = mk("rwi",     3'b101, 12'h010, 64'h1F,        5'd31, 5'd9,  1, 64'hAAAA,      1, 64'h1F,        64'hAAAA,      0);
        vecs[5]  = mk("rsi_z0",  3'b110, 12'h010, 64'h0,         5'd0,  5'd10, 0, 64'h0,         0, 64'h0,         64'h1F,        0);
        vecs[6]  = mk("rci",     3'b111, 12'h010, 64'h3,         5'd3,  5'd11, 0, 64'h0,         1, 64'h1C,        64'h1F,        0);
        vecs[7]  = mk("rw_ro",   3'b001, 12'hC01, 64'h5,         5'd0,  5'd12, 1, 64'h66,        0, 64'h0,         64'h0,         1);
        vecs[8]  = mk("rw_bff",  3'b001, 12'hBFF, 64'h55,        5'd0,  5'd13, 1, 64'h7,         1, 64'h55,        64'h7,         0);
        vecs[9]  = mk("rc_ro_z", 3'b011, 12'hC02, 64'h0,         5'd0,  5'd14, 1, 64'h88,        0, 64'h0,         64'h88,        0);
        vecs[10] = mk("rsi_ro",  3'b110, 12'hFFF, 64'h1,         5'd1,  5'd31, 1, 64'h1,         0, 64'h0,         64'h0,         1);
        vecs[11] = mk("f3_000",  3'b000, 12'h006, 64'h2,         5'd2,  5'd1,  1, 64'h9,         0, 64'h0,         64'h0,         1);

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        check("rst req_ready", 64'(req_ready), 64'd1);
        check("rst resp_valid", 64'(resp_valid), 64'd0);
        check("rst csr_we", 64'(csr_we), 64'd0);
        check("rst csr_raddr", 64'(csr_raddr), 64'd0);
        check("rst perf_ops", 64'(perf_ops), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst req_ready", 64'(req_ready), 64'd1);
        check("post_rst resp_rdata", resp_rdata, 64'd0);

        // ---------------- reset during an access ----------------
        preload(12'h040, 64'h77);
        issue(3'b001, 12'h040, 64'h99, 5'd1, 5'd2);
        check("midrst raddr_in_read", 64'(csr_raddr), 64'h040);
        #2 rst_n = 1'b0;
        #1;
        check("midrst req_ready", 64'(req_ready), 64'd1);
        check("midrst raddr", 64'(csr_raddr), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("midrst csr_we", 64'(csr_we), 64'd0);
        check("midrst resp_valid", 64'(resp_valid), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst csr_kept", csr_mem[12'h040], 64'h77);

        // ---------------- table vectors ----------------
        for (int i = 0; i < 12; i++) run_vec(vecs[i], 0);

        // ---------------- cycle counter reads ----------------
        issue(3'b010, 12'hC00, 64'h0, 5'd0, 5'd3);
        collect(0);
        check("cnt we_count", 64'(obs_we_cnt), 64'd0);
        check("cnt rdata", obs_rdata, obs_cnt_read);
        check("cnt illegal", 64'(obs_ill), 64'd0);
        issue(3'b010, 12'hC00, 64'h5, 5'd3, 5'd3);
        collect(0);
        check("cnt_wr we_count", 64'(obs_we_cnt), 64'd0);
        check("cnt_wr rdata", obs_rdata, 64'd0);
        check("cnt_wr illegal", 64'(obs_ill), 64'd1);

        // ---------------- response back-pressure ----------------
        preload(12'h020, 64'h4);
        preload(12'h021, 64'h1);
        issue(3'b001, 12'h020, 64'h9, 5'd1, 5'd10);
        for (int k = 0; k < 10 && !resp_valid; k++) @(negedge clk);
        check("stall resp_valid", 64'(resp_valid), 64'd1);
        drive_req(3'b010, 12'h021, 64'h10, 5'd1, 5'd11);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall hold_valid", 64'(resp_valid), 64'd1);
            check("stall hold_rdata", resp_rdata, 64'h4);
            check("stall hold_rd", 64'(resp_rd), 64'd10);
            check("stall hold_illegal", 64'(resp_illegal), 64'd0);
            check("stall req_ready", 64'(req_ready), 64'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        exp_ops++;
        check("stall released", 64'(resp_valid), 64'd0);
        check("stall idle_ready", 64'(req_ready), 64'd1);
        check("stall not_accepted", 64'(csr_raddr), 64'd0);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("stall2 accepted", 64'(csr_raddr), 64'h021);
        check("stall2 req_ready", 64'(req_ready), 64'd0);
        collect(0);
        check("stall2 wdata", obs_wdata, 64'h11);
        check("stall2 rdata", obs_rdata, 64'h1);
        check("stall2 rd", 64'(obs_rd), 64'd11);

        // ---------------- flush in READ ----------------
        preload(12'h030, 64'h5);
        issue(3'b001, 12'h030, 64'hFF, 5'd1, 5'd4);
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        check("flush_rd req_ready", 64'(req_ready), 64'd1);
        check("flush_rd resp_valid", 64'(resp_valid), 64'd0);
        for (int k = 0; k < 4; k++) begin
            check("flush_rd no_we", 64'(csr_we), 64'd0);
            check("flush_rd no_resp", 64'(resp_valid), 64'd0);
            @(negedge clk);
        end
        check("flush_rd csr_kept", csr_mem[12'h030], 64'h5);

        // ---------------- flush in IDLE ----------------
        drive_req(3'b001, 12'h031, 64'h1, 5'd1, 5'd4);
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        flush = 1'b0;
        check("flush_idle req_ready", 64'(req_ready), 64'd1);
        check("flush_idle not_accepted", 64'(csr_raddr), 64'd0);
        @(negedge clk);
        check("flush_idle no_resp", 64'(resp_valid), 64'd0);

        // ---------------- flush in WRITE / RESP is ignored ----------------
        run_vec(mk("flush_wr", 3'b001, 12'h050, 64'h123, 5'd1, 5'd20, 1, 64'h0, 1, 64'h123, 64'h0, 0), 2);
        run_vec(mk("flush_resp", 3'b011, 12'h050, 64'h3, 5'd1, 5'd21, 0, 64'h0, 1, 64'h120, 64'h123, 0), 3);

        // ---------------- performance counters ----------------
`ifdef CSR_ACCESS_PERF_EN
        check("perf_ops", 64'(perf_ops), 64'(exp_ops));
        check("perf_illegal", 64'(perf_illegal), 64'(exp_ill));
`else
        check("perf_ops tied", 64'(perf_ops), 64'd0);
        check("perf_illegal tied", 64'(perf_illegal), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
